// File: rtl/hilo_unit.sv
// HI/LO register unit: hands multiply requests to an external multiplier, captures its result,
// and stalls MFHI/MFLO reads while busy. Optional define HILO_MT_EN adds MTHI/MTLO write ports.
module hilo_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_mult,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        op_ack,
   output logic        mul_start,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   input  logic        mul_ready,
   input  logic        rd_hi,
   input  logic        rd_lo,
   output logic [31:0] rd_data,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q,
   output logic        busy,
   output logic        stall,
   output logic        err
`ifdef HILO_MT_EN
   ,
   input  logic        mt_hi,
   input  logic        mt_lo,
   input  logic [31:0] mt_data
`endif
);

   typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_t;

   // Last WAIT count value; the edge leaving it is where the counter reaches 48.
   localparam logic [5:0] CntLast = 6'd47;

   state_t      r_state;
   logic [31:0] r_hi, r_lo, r_a, r_b;
   logic [5:0]  r_cnt;
   logic        r_err, r_start;
   logic        w_accept, w_req;

   assign w_accept = (r_state == StIdle) & op_mult & ~reset;

`ifdef HILO_MT_EN
   assign w_req = rd_hi | rd_lo | mt_hi | mt_lo;
`else
   assign w_req = rd_hi | rd_lo;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_hi    <= '0;
         r_lo    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_start <= 1'b0;
      end else begin
         r_start <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (op_mult) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_start <= 1'b1;
                  r_state <= StLaunch;
               end
`ifdef HILO_MT_EN
               else begin
                  if (mt_hi) r_hi <= mt_data;
                  if (mt_lo) r_lo <= mt_data;
               end
`endif
            end
            StLaunch: begin
               r_cnt   <= '0;
               r_state <= StWait;
            end
            StWait: begin
               r_cnt <= r_cnt + 6'd1;
               // A result arriving on the timeout cycle still counts as completion.
               if (mul_ready) begin
                  r_hi    <= mul_hi;
                  r_lo    <= mul_lo;
                  r_state <= StIdle;
               end else if (r_cnt == CntLast) begin
                  r_err   <= 1'b1;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign op_ack    = w_accept;
   assign mul_start = r_start;
   assign mul_a     = r_a;
   assign mul_b     = r_b;
   assign hi_q      = r_hi;
   assign lo_q      = r_lo;
   assign err       = r_err;
   assign busy      = (r_state == StLaunch) | (r_state == StWait);
   assign stall     = w_req & busy;
   assign rd_data   = rd_hi ? r_hi : (rd_lo ? r_lo : 32'd0);

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have: op_mult  in  1  multiply request from control, held until op_ack.
REQ-004 SHALL have: op_a, op_b  in  32 each  multiply operands, sampled at acceptance.
REQ-005 SHALL have: op_ack  out  1  one-cycle pulse, request accepted.
REQ-006 SHALL have: mul_start  out  1; mul_a, mul_b  out  32 each  drive to multiplier.
REQ-007 SHALL have: mul_hi, mul_lo  in  32 each; mul_ready  in  1  multiplier result and completion pulse.
REQ-008 SHALL have: rd_hi, rd_lo  in  1  MFHI/MFLO read requests; rd_data  out  32.
REQ-009 SHALL have: hi_q, lo_q  out  32  architectural HI/LO registers.
REQ-010 SHALL have: busy  out  1; stall  out  1; err  out  1  sticky timeout flag.
REQ-011 SHALL have, under HILO_MT_EN only: mt_hi, mt_lo  in  1; mt_data  in  32.

Function
REQ-012 SHALL implement FSM IDLE, LAUNCH, WAIT.
REQ-013 IDLE: op_mult=1 SHALL pulse op_ack, latch op_a/op_b into mul_a/mul_b, go LAUNCH next edge.
REQ-014 LAUNCH: mul_start SHALL be 1 for exactly this one cycle; go WAIT next edge; wait counter cleared to 0.
REQ-015 WAIT: counter SHALL increment each cycle; mul_ready=1 SHALL load hi_q<=mul_hi, lo_q<=mul_lo on that edge and go IDLE.
REQ-016 WAIT: counter reaching 48 without mul_ready SHALL go IDLE, set err=1, leave hi_q/lo_q unchanged.
REQ-017 mul_ready and counter==48 in same cycle SHALL be treated as completion (capture, err unchanged).
REQ-018 mul_ready outside WAIT SHALL be ignored (stale pulse after reset or timeout).
REQ-019 busy SHALL be 1 exactly when state is LAUNCH or WAIT.
REQ-020 op_mult while busy SHALL not be acknowledged; request stays pending, accepted first IDLE cycle.
REQ-021 rd_data SHALL be combinational: hi_q if rd_hi, else lo_q if rd_lo, else 0; rd_hi wins if both set.
REQ-022 stall SHALL be (rd_hi|rd_lo|mt_hi|mt_lo) & busy, combinational; mt terms absent without HILO_MT_EN.
REQ-023 Result captured on edge N SHALL be visible on rd_data in cycle N+1 with stall=0 (no same-cycle bypass).
REQ-024 mul_start SHALL be 0 in all states except LAUNCH.

Reset
REQ-025 reset=1 SHALL force within the same cycle: state IDLE, hi_q=0, lo_q=0, mul_a=mul_b=0, counter=0, err=0, op_ack=0, mul_start=0.
REQ-026 Reset mid-operation SHALL abandon the operation; later mul_ready is ignored per REQ-018.
REQ-027 err SHALL clear only on reset.

Configuration
REQ-028 Macro HILO_MT_EN defined: mt_hi/mt_lo/mt_data present; in IDLE, mt_hi loads hi_q<=mt_data, mt_lo loads lo_q<=mt_data, both allowed together.
REQ-029 With HILO_MT_EN: mt_* while busy SHALL stall and be deferred, not written; mt_* coincident with op_mult acceptance SHALL be discarded.
REQ-030 Macro undefined: mt_* ports absent, hi_q/lo_q written only by REQ-015.

Verification
REQ-031 op_a=7, op_b=6, model returns mul_hi=0, mul_lo=42 with mul_ready 34 cycles after mul_start -> one op_ack, one-cycle mul_start, hi_q=0, lo_q=42, busy low next cycle.
REQ-032 rd_lo held high from acceptance onward -> stall=1 throughout LAUNCH/WAIT, stall=0 and rd_data=42 cycle after capture.
REQ-033 Model never asserts mul_ready -> IDLE after 48 WAIT cycles, err=1, hi_q/lo_q unchanged; then mul_ready pulse in IDLE -> no change.
REQ-034 Second op_mult held during busy -> op_ack only in first IDLE cycle, second mul_start follows.
REQ-035 reset pulse in WAIT, then mul_ready 5 cycles later -> IDLE, hi_q=lo_q=0, err=0, no capture.
REQ-036 HILO_MT_EN: mt_hi=1, mt_data=32'hDEADBEEF in IDLE -> hi_q=32'hDEADBEEF next cycle; same during WAIT -> stall=1, no write.
